// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled serial receiver with deglitch filter, parity/framing/break
// detection and a small receive FIFO with valid/ready output and sticky overrun.
`default_nettype none

module uart_rx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int DIV_W       = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int FILTER_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     div,
    input  logic                 rxd,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_perr,
    output logic                 out_ferr,
    output logic                 brk,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam int EW = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [FILTER_BITS-1:0] hist_q;
    logic [FILTER_BITS-1:0] hist_d;
    logic                   filt_q;
    logic                   armed_q;
    state_t                 state_q;
    logic [DIV_W-1:0]       div_q;
    logic [DIV_W-1:0]       cnt_q;
    logic [DIV_W-1:0]       div_clamped;
    logic [IW-1:0]          idx_q;
    logic                   stop_idx_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   pbit_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   brk_q;
    logic                   ovr_q;
    logic                   tick;
    logic                   sample;
    logic                   last_stop;
    logic                   ferr_d;
    logic                   done_d;

    generate
        if (FILTER_BITS > 1) begin : g_filt_multi
            assign hist_d = {hist_q[FILTER_BITS-2:0], rxd};
        end else begin : g_filt_single
            assign hist_d = rxd;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '1;
            filt_q <= 1'b1;
        end else begin
            hist_q <= hist_d;
            if (&hist_q)
                filt_q <= 1'b1;
            else if (~|hist_q)
                filt_q <= 1'b0;
        end
    end

    assign div_clamped = (div < DIV_W'(4)) ? DIV_W'(4) : div;
    assign tick        = (cnt_q == div_q - DIV_W'(1));
    assign sample      = (cnt_q == (div_q >> 1) - DIV_W'(1));
    assign last_stop   = (STOP_BITS == 1) || stop_idx_q;
    assign ferr_d      = ferr_q | ~filt_q;
    assign done_d      = (state_q == S_STOP) && sample && last_stop;

    // A start needs a high line seen in IDLE first, so a held-low break yields one frame only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b1;
            div_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            pbit_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            cnt_q <= (state_q == S_IDLE || tick) ? '0 : cnt_q + DIV_W'(1);
            brk_q <= done_d && (shreg_q == '0) && !pbit_q && ferr_d;
            case (state_q)
                S_IDLE: begin
                    if (filt_q) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q    <= S_START;
                        armed_q    <= 1'b0;
                        div_q      <= div_clamped;
                        stop_idx_q <= 1'b0;
                        pbit_q     <= 1'b0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                    end
                end
                S_START: begin
                    if (sample && filt_q) begin
                        state_q <= S_IDLE;
                        armed_q <= 1'b1;
                    end else if (tick) begin
                        state_q <= S_DATA;
                        idx_q   <= '0;
                    end
                end
                S_DATA: begin
                    if (sample)
                        shreg_q <= {filt_q, shreg_q[DATA_BITS-1:1]};
                    if (tick) begin
                        if (idx_q == IW'(DATA_BITS - 1))
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else
                            idx_q <= idx_q + IW'(1);
                    end
                end
                S_PARITY: begin
                    if (sample) begin
                        pbit_q <= filt_q;
                        perr_q <= ((^shreg_q) ^ filt_q) != (PARITY == 2);
                    end
                    if (tick)
                        state_q <= S_STOP;
                end
                S_STOP: begin
                    if (sample) begin
                        ferr_q <= ferr_d;
                        if (last_stop) begin
                            state_q <= S_IDLE;
                            armed_q <= filt_q;
                        end
                    end else if (tick) begin
                        stop_idx_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   count_q;
    logic          pop;
    logic          full;
    logic          accept;
    logic          drop;

    assign pop    = out_val && out_rdy;
    assign full   = (count_q == (AW+1)'(FIFO_DEPTH));
    assign accept = done_d && (!full || pop);
    assign drop   = done_d && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            if (accept) begin
                mem_q[wr_q] <= {perr_q, ferr_d, shreg_q};
                wr_q        <= wr_q + AW'(1);
            end
            if (pop)
                rd_q <= rd_q + AW'(1);
            if (accept && !pop)
                count_q <= count_q + (AW+1)'(1);
            else if (!accept && pop)
                count_q <= count_q - (AW+1)'(1);
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)
                ovr_q <= 1'b1;
            else if (overrun_clr)
                ovr_q <= 1'b0;
        end
    end

    assign out_val  = (count_q != '0);
    assign out_data = mem_q[rd_q][DATA_BITS-1:0];
    assign out_ferr = mem_q[rd_q][DATA_BITS];
    assign out_perr = mem_q[rd_q][DATA_BITS+1];
    assign brk      = brk_q;
    assign overrun  = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames against uart_rx_fifo (8 data, even parity, 1 stop, depth 4)
// with a scoreboard of expected {perr, ferr, data} entries.
`default_nettype none

module tb_uart_rx_fifo;

    logic        clk;
    logic        rst;
    logic [15:0] div;
    logic        rxd;
    logic        out_val;
    logic        out_rdy;
    logic [7:0]  out_data;
    logic        out_perr;
    logic        out_ferr;
    logic        brk;
    logic        overrun;
    logic        overrun_clr;

    uart_rx_fifo #(
        .DATA_BITS  (8),
        .PARITY     (1),
        .STOP_BITS  (1),
        .DIV_W      (16),
        .FIFO_DEPTH (4),
        .FILTER_BITS(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .div        (div),
        .rxd        (rxd),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .out_perr   (out_perr),
        .out_ferr   (out_ferr),
        .brk        (brk),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         brk_cnt  = 0;
    logic [9:0] sb[$];
    logic [9:0] mon_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every accepted beat is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && brk)
            brk_cnt++;
        if (!rst && out_val && out_rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'({out_perr, out_ferr, out_data}), 32'hFFFF_FFFF);
            end else begin
                mon_exp = sb.pop_front();
                chk("beat", 32'({out_perr, out_ferr, out_data}), 32'(mon_exp));
            end
        end
    end

    // Slot 0 is the start bit, 1..8 data LSB first, 9 even parity (optionally inverted), 10 stop.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input int bt, input int nslots);
        logic [10:0] bits;
        bits = {1'b1, (^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nslots; i++) begin
            rxd = bits[i];
            repeat (bt) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_empty(input string tag, input int maxc);
        int c;
        c = 0;
        while (sb.size() != 0 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        rxd         = 1'b1;
        div         = 16'd16;
        out_rdy     = 1'b1;
        overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_val",  32'(out_val),  32'd0);
        chk("rst_brk",      32'(brk),      32'd0);
        chk("rst_overrun",  32'(overrun),  32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_perr", 32'(out_perr), 32'd0);
        chk("rst_out_ferr", 32'(out_ferr), 32'd0);
        idle(16);

        // Good frame and a parity-error frame
        sb.push_back({1'b0, 1'b0, 8'h55});
        send_frame(8'h55, 1'b0, 16, 11);
        idle(32);
        wait_empty("good_55_drain", 200);
        sb.push_back({1'b1, 1'b0, 8'hA3});
        send_frame(8'hA3, 1'b1, 16, 11);
        idle(32);
        wait_empty("perr_A3_drain", 200);

        // False start, then a good frame proves the receiver is back in IDLE
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        idle(20 * 16);
        chk("false_start_val", 32'(out_val), 32'd0);
        sb.push_back({1'b0, 1'b0, 8'h3C});
        send_frame(8'h3C, 1'b0, 16, 11);
        idle(32);
        wait_empty("after_false_drain", 200);

        // Overrun: five frames into a four-deep FIFO with no consumer
        out_rdy = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4)
                sb.push_back({2'b00, 8'(k)});
            send_frame(8'(k), 1'b0, 16, 11);
            idle(16);
        end
        chk("ovr_set",     32'(overrun), 32'd1);
        chk("ovr_full_val", 32'(out_val), 32'd1);
        out_rdy = 1'b1;
        wait_empty("ovr_drain", 100);
        @(negedge clk);
        chk("ovr_empty_val", 32'(out_val), 32'd0);
        chk("ovr_sticky",    32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Break: line held low for 20 bit-times
        brk_cnt = 0;
        sb.push_back({1'b0, 1'b1, 8'h00});
        rxd = 1'b0;
        repeat (20 * 16) @(negedge clk);
        chk("brk_drain",  32'(sb.size()), 32'd0);
        chk("brk_pulses", 32'(brk_cnt),   32'd1);
        idle(64);
        chk("brk_no_more_val", 32'(out_val), 32'd0);
        chk("brk_pulses_end",  32'(brk_cnt), 32'd1);

        // Reset in the middle of a frame with a stale entry already queued
        out_rdy = 1'b0;
        send_frame(8'h11, 1'b0, 16, 11);
        idle(16);
        chk("pre_rst_val", 32'(out_val), 32'd1);
        send_frame(8'h33, 1'b0, 16, 5);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_val",  32'(out_val),  32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        chk("midrst_ovr",  32'(overrun),  32'd0);
        chk("midrst_brk",  32'(brk),      32'd0);
        out_rdy = 1'b1;
        idle(32);
        sb.push_back({1'b0, 1'b0, 8'h7E});
        send_frame(8'h7E, 1'b0, 16, 11);
        idle(32);
        wait_empty("post_rst_drain", 200);

        // Divisor change mid-frame only takes effect on the following frame
        sb.push_back({1'b0, 1'b0, 8'hC5});
        fork
            send_frame(8'hC5, 1'b0, 16, 11);
            begin
                repeat (5 * 16) @(negedge clk);
                div = 16'd8;
            end
        join
        idle(16);
        sb.push_back({1'b0, 1'b0, 8'h9A});
        send_frame(8'h9A, 1'b0, 8, 11);
        idle(32);
        wait_empty("div_change_drain", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised asynchronous serial receiver, the next generation of the LCD/console RS-232 receive path. Adds:
- configurable data width, parity and stop bits;
- a runtime baud divisor;
- false-start rejection, parity/framing/break detection;
- a small receive FIFO with valid/ready output handshake and a sticky overrun flag.

Sits between the board RxD pin and the console/LCD command consumer.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked (1 or 2)
DIV_W, 16, width of baud divisor input
FIFO_DEPTH, 4, receive FIFO entries (power of two, >=2)
FILTER_BITS, 2, input deglitch history length

Ports:
clk  in  1  clock
rst  in  1  reset rst, synchronous, active-high
div  in  DIV_W  clocks per bit; values <4 treated as 4
rxd  in  1  raw serial input, idle high, asynchronous
out_val  out  1  FIFO non-empty
out_rdy  in  1  consumer accepts head entry
out_data  out  DATA_BITS  head entry data
out_perr  out  1  head entry parity error (0 when PARITY=0)
out_ferr  out  1  head entry framing error
brk  out  1  one-cycle pulse on break frame
overrun  out  1  sticky: frame dropped because FIFO full
overrun_clr  in  1  clears overrun

Behaviour:
- Reset:
  - filter history all-ones, filtered line = 1, state IDLE, counters 0, FIFO empty.
  - out_val=0, brk=0, overrun=0; out_data/out_perr/out_ferr = 0.
- Filter:
  - history shifts rxd in each cycle.
  - Filtered line updates only when all FILTER_BITS history bits are equal; it takes that value.
- Divisor: div latched (after clamp) into div_q when the start edge is detected; held for the entire frame. Changes to div mid-frame have no effect until the next frame.
- Bit timer cnt:
  - counts 0..div_q-1; tick = (cnt == div_q-1); sample = (cnt == (div_q>>1)-1).
  - cnt = 0 on start detection.
- States:
  - IDLE: filtered==0 -> START, latch div_q, cnt=0.
  - START: at sample, filtered==1 -> IDLE (false start, nothing pushed); otherwise continue; on tick -> DATA, bit index 0.
  - DATA: at sample, shift filtered into data register (LSB first). On tick, index==DATA_BITS-1 -> PARITY if PARITY!=0, else STOP; otherwise index+1.
  - PARITY: at sample, perr = (XOR of data bits XOR sampled bit) != (PARITY==2). On tick -> STOP.
  - STOP: at sample, ferr |= (filtered==0).
    - If more stop bits remain, wait for tick and sample again.
    - At the last stop bit's sample: frame complete, push, go IDLE the same cycle. No wait for tick, to allow resync on the next start bit.
- Break: complete frame with all data bits 0, parity bit 0 (if present) and ferr=1 -> brk pulses 1 the cycle after completion. Entry is still pushed with ferr=1.
- FIFO:
  - push at frame completion; pop when out_val && out_rdy.
  - Head entry visible the cycle after push (1-cycle latency from last stop sample to out_val).
  - Push while full without a same-cycle pop: frame dropped, overrun set next cycle.
  - Push while full with a same-cycle pop: accepted, occupancy unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- overrun_clr and an overrun event in the same cycle: overrun stays 1.
- Reset mid-frame: frame discarded, FIFO emptied, all outputs to reset values the next cycle.

Test Plan:
- div=16, PARITY=1, send 0x55 with correct even parity, 1 stop, out_rdy=1 -> one beat out_data=0x55, perr=0, ferr=0, out_val 1 cycle after stop midpoint.
- Same config, send 0xA3 with parity bit inverted -> out_data=0xA3, perr=1, ferr=0.
- rxd low for 5 cycles then high, div=16 -> false start rejected, out_val stays 0, state back to IDLE.
- out_rdy=0, send 5 frames 0x01..0x05, FIFO_DEPTH=4 -> overrun=1; then drain: 0x01,0x02,0x03,0x04, out_val=0 after; pulse overrun_clr -> overrun=0.
- Hold rxd low for 20 bit-times -> one entry data=0x00, ferr=1, brk single-cycle pulse; no further frame until rxd returns high then falls.
- Assert rst during DATA bit 4 of a frame, then send 0x7E -> first frame lost, only 0x7E delivered. Change div 16->8 mid-frame -> current frame still decoded at 16, next frame decoded at 8.
